core_lsu: RTL and testbench

Load/store unit directly downstream of the ALU in the execute/memory boundary of the RV32I core.
- Takes the ALU result as the effective address plus rs2 store data and the funct3 width code.
- Performs one data-memory access over a simple req/ack bus and returns a sign- or zero-extended load result with destination register tag.
- Asserts stall to the pipeline while an access is outstanding.

---
 rtl/core_lsu.sv | 191 +++++++++++++++++++
 tb/tb_core_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// RV32I load/store unit: one req/ack data-memory access per accepted op, with lane steering and load extension.
// Optional bus watchdog is compiled in when LSU_TIMEOUT_EN is defined.
module core_lsu #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              we_in,
    input  logic [2:0]        op_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [4:0]        rd_in,
    output logic              resp_valid_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic [4:0]        rd_out,
    output logic              excp_out,
    output logic              timeout_out,
    output logic              stall_out,
    output logic              bus_req_out,
    output logic              bus_we_out,
    output logic [DATA_W-1:0] bus_addr_out,
    output logic [3:0]        bus_be_out,
    output logic [DATA_W-1:0] bus_wdata_out,
    input  logic              bus_ack_in,
    input  logic [DATA_W-1:0] bus_rdata_in
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              excp_q, excp_d;
    logic              expire;

    // Accept-time checks use the incoming op so a bad request never reaches the bus.
    logic is_half_in, is_word_in, misaligned_in, illegal_in;
    assign is_half_in    = (op_in[1:0] == 2'b01);
    assign is_word_in    = op_in[1];
    assign misaligned_in = (is_half_in & addr_in[0]) | (is_word_in & (addr_in[1:0] != 2'b00));
    assign illegal_in    = we_in ? op_in[2] : ((op_in == 3'b011) || (op_in[2:1] == 2'b11));

    logic [3:0]        be;
    logic [DATA_W-1:0] store_lanes;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_ext;

    always_comb begin
        be          = 4'b1111;
        store_lanes = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                be          = 4'b0001 << addr_q[1:0];
                store_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be          = addr_q[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = bus_rdata_in >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = lane;
        case (op_q)
            3'b000:  load_ext = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        excp_d  = excp_q;
        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    we_d    = we_in;
                    op_d    = op_in;
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    rd_d    = rd_in;
                    rdata_d = '0;
                    excp_d  = misaligned_in | illegal_in;
                    state_d = (misaligned_in | illegal_in) ? RESP : BUS;
                end
            end
            BUS: begin
                if (bus_ack_in) begin
                    rdata_d = we_q ? '0 : load_ext;
                    state_d = RESP;
                end else if (expire) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 5'd0;
            excp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            excp_q  <= excp_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // Expiry is the last counted wait cycle; an ack in that cycle takes priority in the FSM.
    assign expire = (state_q == BUS) && !bus_ack_in && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE && req_valid_in) begin
            cnt_d     = 8'd0;
            timeout_d = 1'b0;
        end else if (state_q == BUS && !bus_ack_in) begin
            cnt_d = cnt_q + 8'd1;
            if (expire) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = (state_q == RESP) & timeout_q;
`else
    assign expire      = 1'b0;
    assign timeout_out = 1'b0;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_limit_unrepresentable
    end
`endif

    assign req_ready_out  = (state_q == IDLE);
    assign stall_out      = (state_q != IDLE);
    assign bus_req_out    = (state_q == BUS);
    assign bus_we_out     = bus_req_out & we_q;
    assign bus_addr_out   = bus_req_out ? {addr_q[DATA_W-1:2], 2'b00} : '0;
    assign bus_be_out     = bus_req_out ? be : 4'b0000;
    assign bus_wdata_out  = (bus_req_out & we_q) ? store_lanes : '0;
    assign resp_valid_out = (state_q == RESP);
    assign rdata_out      = resp_valid_out ? rdata_q : '0;
    assign excp_out       = resp_valid_out & excp_q;
    assign rd_out         = rd_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed and random load/store ops against a byte-lane reference model.
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        we_in;
    logic [2:0]  op_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [4:0]  rd_in;
    logic        resp_valid_out;
    logic [31:0] rdata_out;
    logic [4:0]  rd_out;
    logic        excp_out;
    logic        timeout_out;
    logic        stall_out;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [3:0]  bus_be_out;
    logic [31:0] bus_wdata_out;
    logic        bus_ack_in;
    logic [31:0] bus_rdata_in;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .we_in          (we_in),
        .op_in          (op_in),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .rd_in          (rd_in),
        .resp_valid_out (resp_valid_out),
        .rdata_out      (rdata_out),
        .rd_out         (rd_out),
        .excp_out       (excp_out),
        .timeout_out    (timeout_out),
        .stall_out      (stall_out),
        .bus_req_out    (bus_req_out),
        .bus_we_out     (bus_we_out),
        .bus_addr_out   (bus_addr_out),
        .bus_be_out     (bus_be_out),
        .bus_wdata_out  (bus_wdata_out),
        .bus_ack_in     (bus_ack_in),
        .bus_rdata_in   (bus_rdata_in)
    );

    // Access size in bytes for a funct3 code; 0 means the op is not a legal RV32I access.
    function automatic int op_size(input logic we, input logic [2:0] op);
        if (we) begin
            case (op)
                3'b000:  return 1;
                3'b001:  return 2;
                3'b010:  return 4;
                default: return 0;
            endcase
        end
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_excp(input logic we, input logic [2:0] op, input logic [31:0] addr);
        int sz = op_size(we, op);
        if (sz == 0) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] op, input logic [31:0] addr);
        int sz = op_size(we, op);
        logic [7:0] m = 8'((1 << sz) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        int sz = op_size(1'b1, op);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        int sz = op_size(1'b0, op);
        logic [31:0] mask, v;
        if (sz == 4) return d;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (d >> (8 * (addr % 4))) & mask;
        if (op[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Presents one op at the current negedge and follows it to completion.
    // garble keeps req_valid_in high with changing fields while the LSU is busy.
    task automatic run_op(input string name, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int ack_wait, input logic [31:0] bdata, input bit garble);
        logic        e_excp  = model_excp(we, op, addr);
        logic [3:0]  e_be    = e_excp ? 4'b0000 : model_be(we, op, addr);
        logic [31:0] e_wd    = (we && !e_excp) ? model_wdata(op, wd) : 32'h0;
        logic [31:0] e_rdata = (we || e_excp) ? 32'h0 : model_rdata(op, addr, bdata);
        logic [31:0] e_addr  = addr & 32'hFFFF_FFFC;

        total++; if (req_ready_out !== 1'b1) begin bad++; $display("FAIL %s ready_before got=%b exp=1", name, req_ready_out); end
        req_valid_in = 1'b1; we_in = we; op_in = op; addr_in = addr; wdata_in = wd; rd_in = rd;
        @(negedge clk);
        if (garble) begin
            we_in = 1'($urandom); op_in = 3'($urandom); addr_in = $urandom; wdata_in = $urandom; rd_in = 5'($urandom);
        end else begin
            req_valid_in = 1'b0;
        end
        if (!e_excp) begin
            for (int w = 0; w <= ack_wait; w++) begin
                total++; if (bus_req_out !== 1'b1) begin bad++; $display("FAIL %s bus_req w=%0d got=%b exp=1", name, w, bus_req_out); end
                total++; if (bus_we_out !== we) begin bad++; $display("FAIL %s bus_we got=%b exp=%b", name, bus_we_out, we); end
                total++; if (bus_addr_out !== e_addr) begin bad++; $display("FAIL %s bus_addr got=%h exp=%h", name, bus_addr_out, e_addr); end
                total++; if (bus_be_out !== e_be) begin bad++; $display("FAIL %s bus_be got=%b exp=%b", name, bus_be_out, e_be); end
                if (we) begin
                    total++; if (bus_wdata_out !== e_wd) begin bad++; $display("FAIL %s bus_wdata got=%h exp=%h", name, bus_wdata_out, e_wd); end
                end
                total++; if (stall_out !== 1'b1 || resp_valid_out !== 1'b0) begin bad++; $display("FAIL %s busy_flags got stall=%b resp=%b exp stall=1 resp=0", name, stall_out, resp_valid_out); end
                if (w == ack_wait) begin bus_ack_in = 1'b1; bus_rdata_in = bdata; end
                else bus_rdata_in = $urandom;
                @(negedge clk);
                bus_ack_in = 1'b0;
                bus_rdata_in = $urandom;
                if (garble) begin addr_in = $urandom; op_in = 3'($urandom); end
            end
        end
        req_valid_in = 1'b0;
        total++; if (resp_valid_out !== 1'b1) begin bad++; $display("FAIL %s resp_valid got=%b exp=1", name, resp_valid_out); end
        total++; if (excp_out !== e_excp) begin bad++; $display("FAIL %s excp got=%b exp=%b", name, excp_out, e_excp); end
        total++; if (rdata_out !== e_rdata) begin bad++; $display("FAIL %s rdata got=%h exp=%h", name, rdata_out, e_rdata); end
        total++; if (rd_out !== rd) begin bad++; $display("FAIL %s rd got=%0d exp=%0d", name, rd_out, rd); end
        total++; if (timeout_out !== 1'b0 || bus_req_out !== 1'b0 || stall_out !== 1'b1) begin bad++; $display("FAIL %s resp_flags got to=%b breq=%b stall=%b exp 0 0 1", name, timeout_out, bus_req_out, stall_out); end
        @(negedge clk);
        total++; if (resp_valid_out !== 1'b0 || rdata_out !== 32'h0 || excp_out !== 1'b0) begin bad++; $display("FAIL %s after_resp got resp=%b rdata=%h excp=%b exp 0 0 0", name, resp_valid_out, rdata_out, excp_out); end
        $display("op %s we=%b op=%b addr=%h ack_wait=%0d excp=%b rdata=%h", name, we, op, addr, ack_wait, e_excp, e_rdata);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid_in = 1'b0; we_in = 1'b0; op_in = 3'b0; addr_in = 32'h0;
        wdata_in = 32'h0; rd_in = 5'd0; bus_ack_in = 1'b0; bus_rdata_in = 32'h0;
        #3;
        total++; if (req_ready_out !== 1'b1) begin bad++; $display("FAIL reset ready got=%b exp=1", req_ready_out); end
        total++; if ({resp_valid_out, excp_out, timeout_out, stall_out, bus_req_out, bus_we_out} !== 6'b0)
            begin bad++; $display("FAIL reset flags got=%b exp=000000", {resp_valid_out, excp_out, timeout_out, stall_out, bus_req_out, bus_we_out}); end
        total++; if (rdata_out !== 32'h0 || rd_out !== 5'd0 || bus_addr_out !== 32'h0 || bus_be_out !== 4'h0 || bus_wdata_out !== 32'h0)
            begin bad++; $display("FAIL reset buses got rdata=%h rd=%0d addr=%h be=%b wd=%h exp all 0", rdata_out, rd_out, bus_addr_out, bus_be_out, bus_wdata_out); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_directed();
        run_op("lw_0x100",   1'b0, 3'b010, 32'h100, 32'h0,         5'd1, 3, 32'hDEADBEEF, 1'b0);
        run_op("lb_0x103",   1'b0, 3'b000, 32'h103, 32'h0,         5'd2, 0, 32'h80FF0000, 1'b0);
        run_op("lbu_0x103",  1'b0, 3'b100, 32'h103, 32'h0,         5'd3, 1, 32'h80FF0000, 1'b0);
        run_op("lhu_0x102",  1'b0, 3'b101, 32'h102, 32'h0,         5'd4, 0, 32'h80FF0000, 1'b0);
        run_op("lh_0x102",   1'b0, 3'b001, 32'h102, 32'h0,         5'd5, 2, 32'h80FF0000, 1'b0);
        run_op("sh_0x202",   1'b1, 3'b001, 32'h202, 32'h1234ABCD,  5'd6, 1, 32'hFFFFFFFF, 1'b0);
        run_op("sb_0x301",   1'b1, 3'b000, 32'h301, 32'h000000A5,  5'd7, 0, 32'h0, 1'b0);
        run_op("sw_0x400",   1'b1, 3'b010, 32'h400, 32'hCAFEF00D,  5'd8, 2, 32'h0, 1'b0);
    endtask

    task automatic test_exceptions();
        run_op("lw_misalign",  1'b0, 3'b010, 32'h101, 32'h0, 5'd9,  0, 32'h12345678, 1'b0);
        run_op("store_op100",  1'b1, 3'b100, 32'h200, 32'h5, 5'd10, 0, 32'h0, 1'b0);
        run_op("lh_misalign",  1'b0, 3'b001, 32'h103, 32'h0, 5'd11, 0, 32'h0, 1'b0);
        run_op("load_op011",   1'b0, 3'b011, 32'h100, 32'h0, 5'd12, 0, 32'h0, 1'b0);
        run_op("sw_misalign",  1'b1, 3'b010, 32'h202, 32'h9, 5'd13, 0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++) begin
            logic        we = 1'($urandom);
            logic [2:0]  op = 3'($urandom);
            logic [31:0] a  = $urandom;
            if (we && op == 3'b011) op = 3'b010;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op($sformatf("rand%0d", i), we, op, a, $urandom, 5'($urandom),
                   $urandom_range(0, 3), $urandom, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_access();
        req_valid_in = 1'b1; we_in = 1'b0; op_in = 3'b010; addr_in = 32'h500; rd_in = 5'd20;
        @(negedge clk);
        req_valid_in = 1'b0;
        total++; if (bus_req_out !== 1'b1) begin bad++; $display("FAIL midrst bus_req_before got=%b exp=1", bus_req_out); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus_req_out !== 1'b0 || stall_out !== 1'b0 || req_ready_out !== 1'b1)
            begin bad++; $display("FAIL midrst async got breq=%b stall=%b ready=%b exp 0 0 1", bus_req_out, stall_out, req_ready_out); end
        bus_ack_in = 1'b1; bus_rdata_in = 32'h11111111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (resp_valid_out !== 1'b0 || bus_req_out !== 1'b0) begin bad++; $display("FAIL midrst in_reset c=%0d got resp=%b breq=%b exp 0 0", c, resp_valid_out, bus_req_out); end
        end
        bus_ack_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready_out !== 1'b1 || resp_valid_out !== 1'b0) begin bad++; $display("FAIL midrst after_release got ready=%b resp=%b exp 1 0", req_ready_out, resp_valid_out); end
        run_op("lw_after_rst", 1'b0, 3'b010, 32'h504, 32'h0, 5'd21, 1, 32'h0BADF00D, 1'b0);
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 0;
        req_valid_in = 1'b1; we_in = 1'b0; op_in = 3'b010; addr_in = 32'h600; rd_in = 5'd22;
        @(negedge clk);
        req_valid_in = 1'b0;
        while (bus_req_out === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        total++; if (cyc != 16) begin bad++; $display("FAIL timeout req_cycles got=%0d exp=16", cyc); end
        total++; if (resp_valid_out !== 1'b1 || timeout_out !== 1'b1 || rdata_out !== 32'h0 || excp_out !== 1'b0)
            begin bad++; $display("FAIL timeout resp got resp=%b to=%b rdata=%h excp=%b exp 1 1 0 0", resp_valid_out, timeout_out, rdata_out, excp_out); end
        @(negedge clk);
        total++; if (resp_valid_out !== 1'b0 || timeout_out !== 1'b0) begin bad++; $display("FAIL timeout after got resp=%b to=%b exp 0 0", resp_valid_out, timeout_out); end
        run_op("ack_on_expiry", 1'b0, 3'b010, 32'h604, 32'h0, 5'd23, 15, 32'h76543210, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_exceptions();
        test_back_to_back();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
